fifo_tx_serializer: RTL and testbench

- Downstream consumer of the FIFO: pops one word at a time and shifts it out LSB-first on a single-wire, UART-style frame (start bit, WIDTH data bits, optional parity bit, stop bit).
- Connects directly to the FIFO's empty, pop and out ports.
- Each bit is held for DIV clock cycles.

---
 rtl/fifo_tx_serializer.sv | 199 +++++++++++++++++++
 tb/tb_fifo_tx_serializer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_tx_serializer.sv
// fifo_tx_serializer: pops words from a FIFO and shifts each one out LSB-first
// as a UART-style frame (start bit, WIDTH data bits, optional parity, stop bit).
// Each serial bit is held for DIV clock cycles.
// Optional feature macro: FIFO_TX_PARITY_EN (adds an even-parity bit after the data).
// All outputs are registered; they are computed from the next-state values so
// they line up exactly with the state register.
module fifo_tx_serializer #(
  parameter int WIDTH = 4,
  parameter int DIV   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_pop,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  localparam int CW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DVW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  BIT_LAST = CW'(WIDTH - 1);
  localparam logic [DVW-1:0] DIV_LAST = DVW'(DIV - 1);

`ifdef FIFO_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP   = 3'd1,
    CAPT  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    PAR   = 3'd5,
    STOP  = 3'd6
  } state_t;

  // Even parity of a whole data word.
  function automatic logic even_parity(input logic [WIDTH-1:0] word);
    return ^word;
  endfunction
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP   = 3'd1,
    CAPT  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd6
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [DVW-1:0]   div_q, div_d;
  logic [CW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             fifo_pop_q, fifo_pop_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bit_end_s;
`ifdef FIFO_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  assign bit_end_s = (div_q == DIV_LAST);

  // Next-state, divider, bit counter and shift register update.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
`ifdef FIFO_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (en && !fifo_empty) begin
          state_d = POP;
        end else begin
          state_d = IDLE;
        end
      end
      POP: begin
        state_d = CAPT;
      end
      CAPT: begin
        // FIFO output is valid now, one cycle after the pop.
        shreg_d = fifo_data;
`ifdef FIFO_TX_PARITY_EN
        par_d   = even_parity(fifo_data);
`endif
        div_d   = {DVW{1'b0}};
        bit_d   = {CW{1'b0}};
        state_d = START;
      end
      START: begin
        if (bit_end_s) begin
          div_d   = {DVW{1'b0}};
          state_d = DATA;
        end else begin
          div_d = div_q + DVW'(1);
        end
      end
      DATA: begin
        if (bit_end_s) begin
          div_d   = {DVW{1'b0}};
          shreg_d = shreg_q >> 1;
          if (bit_q == BIT_LAST) begin
            bit_d   = {CW{1'b0}};
`ifdef FIFO_TX_PARITY_EN
            state_d = PAR;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + CW'(1);
          end
        end else begin
          div_d = div_q + DVW'(1);
        end
      end
`ifdef FIFO_TX_PARITY_EN
      PAR: begin
        if (bit_end_s) begin
          div_d   = {DVW{1'b0}};
          state_d = STOP;
        end else begin
          div_d = div_q + DVW'(1);
        end
      end
`endif
      STOP: begin
        if (bit_end_s) begin
          div_d   = {DVW{1'b0}};
          state_d = IDLE;
        end else begin
          div_d = div_q + DVW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        div_d   = {DVW{1'b0}};
        bit_d   = {CW{1'b0}};
      end
    endcase
  end

  // Output values for the upcoming cycle, derived from the next state.
  always_comb begin
    fifo_pop_d = (state_d == POP);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == STOP) && (div_d == DIV_LAST);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
`ifdef FIFO_TX_PARITY_EN
      PAR:     tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  // State and output registers with synchronous reset; reset aborts any frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      div_q      <= {DVW{1'b0}};
      bit_q      <= {CW{1'b0}};
      shreg_q    <= {WIDTH{1'b0}};
      fifo_pop_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef FIFO_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      fifo_pop_q <= fifo_pop_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef FIFO_TX_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  assign fifo_pop = fifo_pop_q;
  assign tx       = tx_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_fifo_tx_serializer.sv
// Testbench for fifo_tx_serializer: a small FIFO model feeds the DUT, words are
// queued as expectations when pushed, and a serial receiver decodes each frame
// from tx and compares it against the queue.
module tb_fifo_tx_serializer;

  localparam int W = 4;
  localparam int D = 2;
`ifdef FIFO_TX_PARITY_EN
  localparam int NB = W + 3;
`else
  localparam int NB = W + 2;
`endif
  localparam int FLEN     = NB * D;
  localparam int BUSY_LEN = 2 + FLEN;
  localparam int GAP      = BUSY_LEN + 1;

  logic         clk;
  logic         rst;
  logic         en;
  logic         fifo_empty;
  logic [W-1:0] fifo_data;
  logic         fifo_pop;
  logic         tx;
  logic         busy;
  logic         done;

  fifo_tx_serializer #(.WIDTH(W), .DIV(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_pop  (fifo_pop),
    .tx        (tx),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int pop_cnt    = 0;
  int done_cnt   = 0;
  int brun       = 0;
  int pop_cyc    = -1;
  bit prev_pop   = 1'b0;
  bit rx_active  = 1'b0;
  bit gap_chk    = 1'b0;
  bit pop_pend   = 1'b0;
  logic [W-1:0] fq[$];
  logic [W-1:0] exp_q[$];
  logic         rx_buf[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [W-1:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic decode_frame();
    logic [W-1:0] got;
    logic [W-1:0] expw;
    logic         shape;
    shape = 1'b1;
    got   = '0;
    expw  = '0;
    for (int i = 0; i < D; i++) begin
      if (rx_buf[i] !== 1'b0) shape = 1'b0;
      if (rx_buf[FLEN-D+i] !== 1'b1) shape = 1'b0;
    end
    for (int b = 0; b < W; b++) begin
      got[b] = rx_buf[(1+b)*D];
      for (int i = 0; i < D; i++) begin
        if (rx_buf[(1+b)*D+i] !== got[b]) shape = 1'b0;
      end
    end
    if (exp_q.size() == 0) begin
      check("frame_unexpected", 32'd1, 32'd0);
    end else begin
      expw = exp_q.pop_front();
      check("frame_word", 32'(got), 32'(expw));
    end
`ifdef FIFO_TX_PARITY_EN
    for (int i = 0; i < D; i++) begin
      if (rx_buf[(W+1)*D+i] !== rx_buf[(W+1)*D]) shape = 1'b0;
    end
    check("parity_bit", 32'(rx_buf[(W+1)*D]), 32'(^expw));
`endif
    check("frame_shape", 32'(shape), 32'd1);
    check("done_at_stop_end", 32'(done), 32'd1);
  endtask

  // One clock: FIFO model update, protocol checks and frame reception.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (pop_pend) begin
      if (fq.size() > 0) fifo_data = fq.pop_front();
      fifo_empty = (fq.size() == 0);
      pop_pend   = 1'b0;
    end
    if (rst) begin
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_pop", 32'(fifo_pop), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      rx_active = 1'b0;
      rx_buf.delete();
      brun     = 0;
      prev_pop = 1'b0;
    end else begin
      if (fifo_pop) begin
        check("pop_one_cycle", 32'(prev_pop), 32'd0);
        check("pop_nonempty", 32'(fq.size() != 0), 32'd1);
        if (gap_chk && pop_cyc >= 0) check("pop_period", 32'(cyc - pop_cyc), 32'(GAP));
        pop_cnt++;
        pop_cyc  = cyc;
        pop_pend = 1'b1;
      end
      if (done) begin
        done_cnt++;
        check("done_pop_excl", 32'(fifo_pop), 32'd0);
      end
      if (busy) begin
        brun++;
      end else if (brun != 0) begin
        check("busy_len", 32'(brun), 32'(BUSY_LEN));
        brun = 0;
      end
      if (!rx_active && tx === 1'b0) begin
        rx_active = 1'b1;
        check("start_latency", 32'(cyc - pop_cyc), 32'd2);
      end
      if (rx_active) begin
        rx_buf.push_back(tx);
        if (rx_buf.size() == FLEN) begin
          decode_frame();
          rx_active = 1'b0;
          rx_buf.delete();
        end
      end
      prev_pop = fifo_pop;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (n < budget && !(fq.size() == 0 && exp_q.size() == 0 && !busy && !pop_pend && !rx_active)) begin
      tick();
      n++;
    end
    check("drain_timeout", 32'(n < budget), 32'd1);
  endtask

  initial begin
    int p0;
    int d0;
    int n;
    logic [W-1:0] lost;

    // Reset hold with a non-empty FIFO and en high.
    rst        = 1'b1;
    en         = 1'b1;
    fifo_empty = 1'b0;
    fifo_data  = '0;
    repeat (3) tick();
    fifo_empty = 1'b1;
    en         = 1'b0;
    rst        = 1'b0;
    tick();
    check("idle_tx", 32'(tx), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);

    // Single word 4'hA.
    en = 1'b1;
    p0 = pop_cnt;
    d0 = done_cnt;
    push_word(4'hA);
    wait_idle(100);
    check("single_pops", 32'(pop_cnt - p0), 32'd1);
    check("single_dones", 32'(done_cnt - d0), 32'd1);

    // Empty FIFO with en high.
    for (int i = 0; i < 20; i++) begin
      tick();
      check("empty_no_pop", 32'(fifo_pop), 32'd0);
      check("empty_tx_idle", 32'(tx), 32'd1);
    end

    // Drain four words back to back.
    gap_chk = 1'b1;
    pop_cyc = -1;
    p0 = pop_cnt;
    d0 = done_cnt;
    for (int i = 0; i < 4; i++) push_word(W'(i));
    wait_idle(400);
    gap_chk = 1'b0;
    check("drain_pops", 32'(pop_cnt - p0), 32'd4);
    check("drain_dones", 32'(done_cnt - d0), 32'd4);
    repeat (10) tick();
    check("drain_stay_idle", 32'(busy), 32'd0);
    check("drain_no_more_pop", 32'(pop_cnt - p0), 32'd4);

    // en dropped mid-frame: frame still completes.
    d0 = done_cnt;
    push_word(4'h6);
    n = 0;
    while (n < 50 && !rx_active) begin tick(); n++; end
    check("en_wait_timeout", 32'(n < 50), 32'd1);
    en = 1'b0;
    wait_idle(100);
    check("en_drop_done", 32'(done_cnt - d0), 32'd1);
    en = 1'b1;

    // Reset during the second data bit.
    push_word(4'h5);
    n = 0;
    while (n < 50 && !(rx_active && rx_buf.size() == 2 * D + 1)) begin tick(); n++; end
    check("rst_wait_timeout", 32'(n < 50), 32'd1);
    d0  = done_cnt;
    rst = 1'b1;
    tick();
    rst  = 1'b0;
    lost = exp_q.pop_front();
    tick();
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    p0 = pop_cnt;
    push_word(4'hC);
    wait_idle(100);
    check("after_rst_pops", 32'(pop_cnt - p0), 32'd1);
    check("after_rst_dones", 32'(done_cnt - d0), 32'd1);

`ifdef FIFO_TX_PARITY_EN
    // Parity frames: 4'h7 has odd ones (parity 1), 4'h3 even (parity 0).
    push_word(4'h7);
    wait_idle(100);
    push_word(4'h3);
    wait_idle(100);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
